// File: rtl/sound_arbiter.sv
// Fixed-priority arbiter sharing one Sound engine among note sources.
// Grants one note at a time, sequences start/abort, watchdog and inter-note gap.
`timescale 1ns/1ps
module sound_arbiter #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned OWN_W       = 2,
    parameter int unsigned OCT_W       = 3,
    parameter int unsigned NOTE_W      = 4,
    parameter int unsigned LEN_W       = 3,
    parameter int unsigned GAP_CYC     = 2_000_000,
    parameter int unsigned TIMEOUT_CYC = 400_000_000,
    parameter int unsigned PREEMPT     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*OCT_W-1:0]    req_octave,
    input  logic [NUM_REQ*NOTE_W-1:0]   req_note,
    input  logic [NUM_REQ*LEN_W-1:0]    req_length,
    input  logic                        snd_over,
    input  logic                        clr_err,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        snd_start,
    output logic                        snd_abort,
    output logic [OCT_W-1:0]            snd_octave,
    output logic [NOTE_W-1:0]           snd_note,
    output logic [LEN_W-1:0]            snd_length,
    output logic [OWN_W-1:0]            owner,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_PLAY, S_GAP} state_t;

    state_t             state, state_nx;
    logic [WD_W-1:0]    wd_cnt, wd_nx;
    logic [GAP_W-1:0]   gap_cnt, gap_nx;
    logic [NUM_REQ-1:0] gnt_nx;
    logic               snd_start_nx, snd_abort_nx, busy_nx, timeout_err_nx;
    logic [OCT_W-1:0]   snd_octave_nx;
    logic [NOTE_W-1:0]  snd_note_nx;
    logic [LEN_W-1:0]   snd_length_nx;
    logic [OWN_W-1:0]   owner_nx;

    logic [OWN_W-1:0]   win;
    logic               any_req, preempt_hit, wd_expire, gap_done;

    // Lowest set index wins.
    function automatic logic [OWN_W-1:0] lowest_req(input logic [NUM_REQ-1:0] r);
        lowest_req = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (r[i]) lowest_req = OWN_W'(i);
        end
    endfunction

    assign win         = lowest_req(req);
    assign any_req     = |req;
    assign preempt_hit = (PREEMPT != 0) && req[0] && (owner != '0);
    assign wd_expire   = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    assign gap_done    = (gap_cnt == GAP_W'(GAP_CYC - 1));

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wd_cnt      <= '0;
            gap_cnt     <= '0;
            gnt         <= '0;
            snd_start   <= 1'b0;
            snd_abort   <= 1'b0;
            snd_octave  <= '0;
            snd_note    <= '0;
            snd_length  <= '0;
            owner       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            wd_cnt      <= wd_nx;
            gap_cnt     <= gap_nx;
            gnt         <= gnt_nx;
            snd_start   <= snd_start_nx;
            snd_abort   <= snd_abort_nx;
            snd_octave  <= snd_octave_nx;
            snd_note    <= snd_note_nx;
            snd_length  <= snd_length_nx;
            owner       <= owner_nx;
            busy        <= busy_nx;
            timeout_err <= timeout_err_nx;
        end
    end

    // Next state; note completion outranks preemption, which outranks the watchdog.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (any_req) state_nx = S_START;
            S_START: state_nx = S_PLAY;
            S_PLAY:  if (snd_over || preempt_hit || wd_expire) state_nx = S_GAP;
            S_GAP:   if (gap_done) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Next values of counters and outputs.
    always_comb begin
        wd_nx          = wd_cnt;
        gap_nx         = gap_cnt;
        gnt_nx         = '0;
        snd_start_nx   = 1'b0;
        snd_abort_nx   = 1'b0;
        snd_octave_nx  = snd_octave;
        snd_note_nx    = snd_note;
        snd_length_nx  = snd_length;
        owner_nx       = owner;
        timeout_err_nx = timeout_err;
        if (clr_err) timeout_err_nx = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    gnt_nx        = NUM_REQ'(1) << win;
                    owner_nx      = win;
                    snd_octave_nx = req_octave[win*OCT_W +: OCT_W];
                    snd_note_nx   = req_note[win*NOTE_W +: NOTE_W];
                    snd_length_nx = req_length[win*LEN_W +: LEN_W];
                end
            end
            S_START: begin
                snd_start_nx = 1'b1;
                wd_nx        = '0;
            end
            S_PLAY: begin
                wd_nx = wd_cnt + WD_W'(1);
                if (snd_over) begin
                    gap_nx = '0;
                end else if (preempt_hit) begin
                    snd_abort_nx = 1'b1;
                    gap_nx       = '0;
                end else if (wd_expire) begin
                    snd_abort_nx   = 1'b1;
                    timeout_err_nx = 1'b1;
                    gap_nx         = '0;
                end
            end
            S_GAP: begin
                gap_nx = gap_cnt + GAP_W'(1);
            end
            default: ;
        endcase
        busy_nx = (state_nx != S_IDLE);
    end

endmodule
